// File: rtl/bist_scan_sequencer.sv
// Scan-BIST run sequencer: drives LFSR, scan enable and MISR through
// counted shift/capture patterns, a final unload and a signature compare.
module bist_scan_sequencer #(
  parameter int                   CHAIN_LEN  = 8,
  parameter int                   N_PATTERNS = 64,
  parameter int                   SIG_WIDTH  = 6,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bist_start,
  input  logic                 bist_abort,
  input  logic [SIG_WIDTH-1:0] misr_sig,
  output logic                 scan_en,
  output logic                 lfsr_load,
  output logic                 lfsr_en,
  output logic                 misr_clear,
  output logic                 misr_en,
  output logic                 busy,
  output logic                 bist_end,
  output logic                 pass_fail
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(N_PATTERNS + 1);
  localparam logic [SW-1:0] LP_SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] LP_PAT_LAST   = PW'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SHIFT,
    S_CAPTURE,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_shift_cnt;
  logic [SW-1:0] w_shift_nxt;
  logic [PW-1:0] r_pat_cnt;
  logic [PW-1:0] w_pat_nxt;
  logic          r_pass;
  logic          w_pass_nxt;
  logic          w_active;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_shift_cnt <= w_shift_nxt;
      r_pat_cnt   <= w_pat_nxt;
      r_pass      <= w_pass_nxt;
    end
  end

  assign w_active = (r_state == S_INIT)    ||
                    (r_state == S_SHIFT)   ||
                    (r_state == S_CAPTURE) ||
                    (r_state == S_FLUSH)   ||
                    (r_state == S_COMPARE);

  always_comb begin
    w_next      = r_state;
    w_shift_nxt = r_shift_cnt;
    w_pat_nxt   = r_pat_cnt;
    w_pass_nxt  = r_pass;
    unique case (r_state)
      S_IDLE: begin
        if (bist_start && !bist_abort)
          w_next = S_INIT;
      end
      S_INIT: begin
        w_pass_nxt  = 1'b0;
        w_shift_nxt = '0;
        w_pat_nxt   = '0;
        w_next      = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_shift_cnt == LP_SHIFT_LAST) begin
          w_shift_nxt = '0;
          w_next      = S_CAPTURE;
        end else begin
          w_shift_nxt = r_shift_cnt + SW'(1);
        end
      end
      S_CAPTURE: begin
        if (r_pat_cnt == LP_PAT_LAST) begin
          w_next = S_FLUSH;
        end else begin
          w_pat_nxt = r_pat_cnt + PW'(1);
          w_next    = S_SHIFT;
        end
      end
      // unload of the last captured response reuses the shift counter
      S_FLUSH: begin
        if (r_shift_cnt == LP_SHIFT_LAST) begin
          w_shift_nxt = '0;
          w_next      = S_COMPARE;
        end else begin
          w_shift_nxt = r_shift_cnt + SW'(1);
        end
      end
      S_COMPARE: begin
        w_pass_nxt = (misr_sig == GOLDEN_SIG);
        w_next     = S_DONE;
      end
      S_DONE: begin
        if (!bist_start)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bist_abort && w_active) begin
      w_next      = S_IDLE;
      w_shift_nxt = '0;
      w_pat_nxt   = '0;
      w_pass_nxt  = 1'b0;
    end
  end

  assign scan_en    = (r_state == S_SHIFT) || (r_state == S_FLUSH);
  assign lfsr_en    = scan_en;
  assign misr_en    = scan_en || (r_state == S_CAPTURE);
  assign lfsr_load  = (r_state == S_INIT);
  assign misr_clear = (r_state == S_INIT);
  assign busy       = w_active;
  assign bist_end   = (r_state == S_DONE);
  assign pass_fail  = r_pass;

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Scoreboard bench: per-run expectations queued at start, checked when
// the run leaves the busy window.
module tb_bist_scan_sequencer;

  localparam int C = 4;
  localparam int N = 3;
  localparam logic [5:0] GOLD = 6'h2B;

  typedef struct {
    int   len;
    int   scan;
    int   misr;
    int   load;
    int   clr;
    logic done;
    logic pass;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic       clk_run;
  logic       bist_start;
  logic       bist_abort;
  logic [5:0] misr_sig;
  logic       scan_en;
  logic       lfsr_load;
  logic       lfsr_en;
  logic       misr_clear;
  logic       misr_en;
  logic       busy;
  logic       bist_end;
  logic       pass_fail;

  logic       start2;
  logic [5:0] misr2;
  logic       scan_en2;
  logic       lfsr_load2;
  logic       lfsr_en2;
  logic       misr_clear2;
  logic       misr_en2;
  logic       busy2;
  logic       bist_end2;
  logic       pass_fail2;

  int n_checks;
  int n_errors;
  exp_t sb[$];

  bist_scan_sequencer #(
    .CHAIN_LEN(C), .N_PATTERNS(N),
    .SIG_WIDTH(6), .GOLDEN_SIG(GOLD)
  ) u_dut (
    .CLK(CLK), .RST(RST),
    .bist_start(bist_start), .bist_abort(bist_abort),
    .misr_sig(misr_sig), .scan_en(scan_en),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en),
    .misr_clear(misr_clear), .misr_en(misr_en),
    .busy(busy), .bist_end(bist_end),
    .pass_fail(pass_fail)
  );

  bist_scan_sequencer #(
    .CHAIN_LEN(1), .N_PATTERNS(1),
    .SIG_WIDTH(6), .GOLDEN_SIG(GOLD)
  ) u_small (
    .CLK(CLK), .RST(RST),
    .bist_start(start2), .bist_abort(1'b0),
    .misr_sig(misr2), .scan_en(scan_en2),
    .lfsr_load(lfsr_load2), .lfsr_en(lfsr_en2),
    .misr_clear(misr_clear2), .misr_en(misr_en2),
    .busy(busy2), .bist_end(bist_end2),
    .pass_fail(pass_fail2)
  );

  initial begin
    CLK = 1'b0;
    forever begin
      #5;
      if (clk_run) CLK = ~CLK;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // run monitor
  int   m_len, m_scan, m_misr, m_load, m_clr, m_run;
  logic m_prev_busy = 1'b0;
  logic m_prev_scan = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    if (busy) begin
      m_len++;
      if (scan_en) begin m_scan++; m_run++; end
      if (misr_en) m_misr++;
      if (lfsr_load) m_load++;
      if (misr_clear) m_clr++;
      if (!scan_en && m_prev_scan) begin
        check("scan_run", m_run, C);
        m_run = 0;
      end
    end
    if (m_prev_busy && !busy) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("run_len", m_len, e.len);
        check("scan_cnt", m_scan, e.scan);
        check("misr_cnt", m_misr, e.misr);
        check("load_cnt", m_load, e.load);
        check("clr_cnt", m_clr, e.clr);
        check("end_flag", bist_end, e.done);
        check("pass", pass_fail, e.pass);
      end
      m_len = 0; m_scan = 0; m_misr = 0;
      m_load = 0; m_clr = 0; m_run = 0;
    end
    m_prev_busy = busy;
    m_prev_scan = scan_en;
  end

  function automatic exp_t full_run(input logic pass);
    exp_t e;
    e.len  = 1 + N * (C + 1) + C + 1;
    e.scan = N * C + C;
    e.misr = N * C + N + C;
    e.load = 1;
    e.clr  = 1;
    e.done = 1'b1;
    e.pass = pass;
    return e;
  endfunction

  task automatic do_run(input exp_t e, input logic [5:0] sig,
                        input int abort_at, input bit hold);
    bit fin;
    fin = 1'b0;
    sb.push_back(e);
    misr_sig   = sig;
    bist_start = 1'b1;
    @(posedge CLK); #1;
    if (!hold) bist_start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (fin) break;
      @(posedge CLK); #1;
      if (bist_abort) bist_abort = 1'b0;
      if (k == abort_at) bist_abort = 1'b1;
      if (bist_end || !busy) fin = 1'b1;
    end
    if (!fin) check("run_timeout", 0, 1);
    if (bist_end && !hold) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge CLK);
    clk_run = 1'b0;
    #2 RST = 1'b1;
    #1;
    check({tag, "_scan"}, scan_en, 0);
    check({tag, "_lfsr"}, {lfsr_load, lfsr_en}, 0);
    check({tag, "_misr"}, {misr_clear, misr_en}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_end"}, bist_end, 0);
    check({tag, "_pass"}, pass_fail, 0);
    RST = 1'b0;
    #1 clk_run = 1'b1;
  endtask

  initial begin
    exp_t e;
    int   cnt;
    n_checks   = 0;
    n_errors   = 0;
    clk_run    = 1'b1;
    RST        = 1'b1;
    bist_start = 1'b0;
    bist_abort = 1'b0;
    misr_sig   = 6'h00;
    start2     = 1'b0;
    misr2      = 6'h00;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_end", bist_end, 0);
    check("rst_pass", pass_fail, 0);
    check("rst_outs", {scan_en, lfsr_load, lfsr_en, misr_clear, misr_en}, 0);
    @(posedge CLK); #1;

    do_run(full_run(1'b1), GOLD, 0, 1'b0);
    check("idle_after_pass", busy, 0);
    check("pass_held", pass_fail, 1);

    do_run(full_run(1'b0), 6'h2A, 0, 1'b0);
    check("fail_held", pass_fail, 0);

    e = '{len: 10, scan: 8, misr: 9, load: 1, clr: 1, done: 1'b0, pass: 1'b0};
    do_run(e, GOLD, 9, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_end", bist_end, 0);
    @(posedge CLK); #1;
    do_run(full_run(1'b1), GOLD, 0, 1'b0);

    do_run(full_run(1'b1), GOLD, 0, 1'b1);
    cnt = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (bist_end && !busy) cnt++;
    end
    check("hold_done", cnt, 10);
    bist_start = 1'b0;
    @(posedge CLK); #1;
    check("drop_end", bist_end, 0);
    check("drop_busy", busy, 0);
    check("drop_pass", pass_fail, 1);

    bist_start = 1'b1;
    bist_abort = 1'b1;
    @(posedge CLK); #1;
    check("sa_idle_busy", busy, 0);
    check("sa_idle_pass", pass_fail, 1);
    bist_start = 1'b0;
    bist_abort = 1'b0;

    misr2  = GOLD;
    start2 = 1'b1;
    @(posedge CLK); #1;
    start2 = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 50; k++) begin
      if (bist_end2) break;
      @(posedge CLK); #1;
      cnt = k;
    end
    check("small_len", cnt, 5);
    check("small_end", bist_end2, 1);
    check("small_pass", pass_fail2, 1);
    @(posedge CLK); #1;

    rst_pulse("rst_idle");
    @(posedge CLK); #1;

    e = '{len: 4, scan: 3, misr: 3, load: 1, clr: 1, done: 1'b0, pass: 1'b0};
    sb.push_back(e);
    misr_sig   = GOLD;
    bist_start = 1'b1;
    @(posedge CLK); #1;
    bist_start = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check("pre_rst_busy", busy, 1);
    rst_pulse("rst_mid");
    repeat (3) @(posedge CLK);
    #1 check("idle_after_rst", busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
